cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU/memory address width; index = bits [6:0], tag = bits [ADDR_W-1:7].
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have these ports:
- clk_1 input 1: the only clock; all state changes on its rising edge.
- rst input 1: reset, asynchronous, active-low.
- cpu_req input 1: CPU request strobe.
- cpu_we input 1: 1 = write, 0 = read.
- cpu_addr input ADDR_W: request address.
- cpu_wdata input DATA_W: write data.
- cpu_rdata output DATA_W: read data, valid while cpu_ack = 1.
- cpu_ack output 1: one-cycle completion pulse.
- c_addr output ADDR_W: address driven to the cache array.
- c_w_rd output 1: cache direction, 1 = write, 0 = read.
- c_wdata output DATA_W: data to write into the cache.
- c_rdata input DATA_W: cache read data.
- c_hit input 1: cache hit flag.
- mem_req output 1: main-memory request.
- mem_we output 1: main-memory write enable.
- mem_addr output ADDR_W: main-memory address.
- mem_wdata output DATA_W: main-memory write data.
- mem_rdata input DATA_W: main-memory read data.
- mem_ack input 1: memory completion, 1 cycle.
- hit_cnt output 16: read-hit count.
- miss_cnt output 16: read-miss count.

Function
REQ-004 SHALL implement a registered FSM with states IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, UPD, RESP.
REQ-005 IDLE: SHALL sample cpu_req=1 and latch cpu_addr, cpu_we and cpu_wdata; SHALL go to LOOKUP if cpu_we=0, else to MEM_WR.
REQ-006 cpu_req SHALL be ignored in every state except IDLE; the latched values SHALL NOT change until the next IDLE acceptance.
REQ-007 LOOKUP (1 cycle): SHALL drive c_addr = latched address and c_w_rd = 0.
- c_hit=1: SHALL capture c_rdata, increment hit_cnt and go to RESP.
- Otherwise: SHALL increment miss_cnt and go to MEM_RD.
REQ-008 MEM_RD: SHALL hold mem_req=1, mem_we=0 and mem_addr = latched address until mem_ack=1; on mem_ack SHALL capture mem_rdata and go to FILL.
REQ-009 mem_ack=1 in the first cycle of mem_req SHALL be accepted; mem_ack while mem_req=0 SHALL be ignored.
REQ-010 FILL (1 cycle): SHALL drive c_w_rd=1, c_addr = latched address and c_wdata = captured memory data; then go to RESP with cpu_rdata = captured data.
REQ-011 MEM_WR (write-through): SHALL hold mem_req=1, mem_we=1, mem_addr and mem_wdata = latched values until mem_ack; then go to UPD.
REQ-012 UPD (1 cycle, write-allocate): SHALL drive c_w_rd=1, c_addr and c_wdata = latched values; then go to RESP.
REQ-013 RESP: SHALL assert cpu_ack=1 for exactly one cycle and return to IDLE.
- A cpu_req held high SHALL be accepted in the following IDLE cycle.
REQ-014 cpu_rdata SHALL hold its last value outside RESP; on writes it SHALL be unchanged.
REQ-015 Latencies, measured from the edge that samples cpu_req to the edge after which cpu_ack is high:
- Read hit: 2 cycles.
- Read miss: 3 + N cycles, where N = cycles mem_req is held before mem_ack.
- Write: 2 + N cycles.
REQ-016 c_w_rd SHALL be 0 in all states other than FILL and UPD; mem_req SHALL be 0 outside MEM_RD and MEM_WR.
REQ-017 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF without wrapping; writes SHALL increment neither counter.
REQ-018 All outputs SHALL be driven from registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE and drive these outputs to 0: cpu_ack, mem_req, mem_we, c_w_rd, cpu_rdata, c_addr, c_wdata, mem_addr, mem_wdata, hit_cnt, miss_cnt.
REQ-020 Reset during MEM_RD or MEM_WR SHALL drop mem_req immediately; the request SHALL be abandoned and no cpu_ack SHALL be issued.
REQ-021 Release of rst SHALL take effect on the next rising edge of clk_1; the first request can be accepted on that edge.

Structure
REQ-022 The FSM state encoding and the index/tag bit-range constants SHALL live in a shared package, cache_pkg.
REQ-023 The saturating counter SHALL be one sub-module, sat_cnt16, instantiated twice; everything else SHALL be flat.

Verification
REQ-024 Hit: preload the cache model with tag/index for 16'h0085 holding 8'h3C; read 16'h0085 -> cpu_ack 2 cycles later, cpu_rdata=8'h3C, hit_cnt=1, mem_req never asserted.
REQ-025 Miss: read 16'h1205 with memory returning 8'hA7 after 3 cycles -> miss_cnt=1, one FILL cycle with c_addr=16'h1205 and c_wdata=8'hA7, cpu_ack with cpu_rdata=8'hA7, total latency 6.
REQ-026 Write: write 8'h55 to 16'h0200 with mem_ack on the first cycle -> mem_we=1, mem_wdata=8'h55, then UPD writes the cache, cpu_ack at cycle 3, counters unchanged.
REQ-027 Reset mid-MEM_RD: assert rst=0 on cycle 2 of mem_req -> mem_req=0 without waiting for a clock edge, no cpu_ack, counters 0; the next read is serviced normally.
REQ-028 Saturation: force 70000 read hits -> hit_cnt=16'hFFFF and it stays there; back-to-back requests with cpu_req held high -> one cpu_ack per request, no request dropped.

Source files
------------

// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : shared FSM encoding and address-field constants for cache_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_MEM_RD = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_MEM_WR = 3'd4;
  localparam logic [2:0] ST_UPD    = 3'd5;
  localparam logic [2:0] ST_RESP   = 3'd6;

  // Address split: index in the low bits, tag above it.
  localparam int C_IDX_LSB = 0;
  localparam int C_IDX_MSB = 6;
  localparam int C_TAG_LSB = 7;

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_sat_cnt16.sv
// ============================================================================
// sat_cnt16 : 16-bit event counter that sticks at 16'hFFFF instead of wrapping
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 16'h0000;
    end else if (inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// cache_ctrl : write-through / write-allocate cache controller, fully
//              registered outputs, with saturating read hit/miss counters
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_w_rd,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_hit_inc;
  logic              w_miss_inc;

  assign w_hit_inc  = (r_state == ST_LOOKUP) &&  c_hit;
  assign w_miss_inc = (r_state == ST_LOOKUP) && !c_hit;

  // Every output is set on the edge that enters the state owning it, so the
  // value is already stable for the whole cycle spent in that state.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      c_addr    <= '0;
      c_w_rd    <= 1'b0;
      c_wdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      c_w_rd  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (cpu_we) begin
              r_state   <= ST_MEM_WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              r_state <= ST_LOOKUP;
              c_addr  <= cpu_addr;
            end
          end
        end
        ST_LOOKUP: begin
          if (c_hit) begin
            cpu_rdata <= c_rdata;
            r_state   <= ST_RESP;
          end else begin
            r_state  <= ST_MEM_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_addr;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            c_w_rd  <= 1'b1;
            c_addr  <= r_addr;
            c_wdata <= mem_rdata;
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          // c_wdata still holds the line fetched from memory.
          cpu_rdata <= c_wdata;
          r_state   <= ST_RESP;
        end
        ST_MEM_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            c_w_rd  <= 1'b1;
            c_addr  <= r_addr;
            c_wdata <= r_wdata;
            r_state <= ST_UPD;
          end
        end
        ST_UPD: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          cpu_ack <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  sat_cnt16 u_hit_cnt (
    .clk   (clk_1),
    .rst   (rst),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_cnt16 u_miss_cnt (
    .clk   (clk_1),
    .rst   (rst),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
// tb_cache_ctrl : randomized self-checking bench for cache_ctrl against a
//                 transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int NSETS  = 128;
  localparam int BUDGET = 64;

  logic              clk_1 = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] c_addr;
  logic              c_w_rd;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              c_hit;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [15:0]       hit_cnt, miss_cnt;

  always #5 clk_1 = ~clk_1;

  cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_1(clk_1), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .c_addr(c_addr), .c_w_rd(c_w_rd), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_hit(c_hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Standalone counter instance: reaching saturation through the controller
  // would take far too many cycles.
  logic        sc_rst, sc_inc;
  logic [15:0] sc_count;
  logic [15:0] sat_obs [4];
  bit          sat_done;

  sat_cnt16 u_sc (.clk(clk_1), .rst(sc_rst), .inc(sc_inc), .count(sc_count));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[C_IDX_MSB:C_IDX_LSB]);
  endfunction

  function automatic int tag_of(input logic [ADDR_W-1:0] a);
    return int'(a >> C_TAG_LSB);
  endfunction

  function automatic logic [DATA_W-1:0] mem_dflt(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Environment: cache array and main memory the DUT talks to.
  bit                cval [NSETS];
  int                ctag [NSETS];
  logic [DATA_W-1:0] cdat [NSETS];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  assign c_hit   = cval[idx_of(c_addr)] && (ctag[idx_of(c_addr)] == tag_of(c_addr));
  assign c_rdata = cdat[idx_of(c_addr)];

  always @(posedge clk_1) begin
    if (c_w_rd) begin
      cval[idx_of(c_addr)] <= 1'b1;
      ctag[idx_of(c_addr)] <= tag_of(c_addr);
      cdat[idx_of(c_addr)] <= c_wdata;
    end else if (pre_we) begin
      cval[idx_of(pre_addr)] <= 1'b1;
      ctag[idx_of(pre_addr)] <= tag_of(pre_addr);
      cdat[idx_of(pre_addr)] <= pre_data;
    end
  end

  // Reference model: which line each set should hold, and what memory holds.
  bit                rval [NSETS];
  int                rtag [NSETS];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [15:0]       exp_hit_cnt, exp_miss_cnt;
  logic [DATA_W-1:0] exp_rdata;

  task automatic run_txn(input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input int n, input bit hold);
    int ix, tg, exp_lat, lat, mcyc, nfill;
    bit exp_hit, done;
    logic [DATA_W-1:0] exp_d, exp_fd, fd;
    logic [ADDR_W-1:0] fa, oma;
    logic [DATA_W-1:0] owd;
    logic ome;
    ix = idx_of(a);
    tg = tag_of(a);
    exp_hit = !we && rval[ix] && (rtag[ix] == tg);
    if (we) ref_mem[a] = wd;
    exp_d  = ref_mem.exists(a) ? ref_mem[a] : mem_dflt(a);
    exp_fd = we ? wd : exp_d;
    exp_lat = we ? 2 + n : (exp_hit ? 2 : 3 + n);
    rval[ix] = 1'b1;
    rtag[ix] = tg;
    if (!we) begin
      if (exp_hit) exp_hit_cnt = sat_inc(exp_hit_cnt);
      else         exp_miss_cnt = sat_inc(exp_miss_cnt);
      exp_rdata = exp_d;
    end

    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    @(posedge clk_1); #1;
    if (!hold) cpu_req = 1'b0;
    lat = 0; mcyc = 0; nfill = 0; done = 1'b0;
    fa = '0; fd = '0; oma = '0; owd = '0; ome = 1'b0;
    while (!done && lat < BUDGET) begin
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_req) begin
        mcyc++;
        if (mcyc == n) begin
          mem_ack = 1'b1;
          ome = mem_we; oma = mem_addr; owd = mem_wdata;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : mem_dflt(mem_addr);
        end
      end
      if (c_w_rd) begin
        nfill++; fa = c_addr; fd = c_wdata;
      end
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
      @(posedge clk_1); #1;
      lat++;
      if (cpu_ack) done = 1'b1;
    end
    mem_ack = 1'b0;
    chk("ack_seen", 32'(done), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit_cnt));
    chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss_cnt));
    chk("mem_cycles", 32'(mcyc), exp_hit ? 32'd0 : 32'(n));
    chk("fill_count", 32'(nfill), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) begin
      chk("fill_addr", 32'(fa), 32'(a));
      chk("fill_data", 32'(fd), 32'(exp_fd));
      chk("mem_we", 32'(ome), 32'(we));
      chk("mem_addr", 32'(oma), 32'(a));
    end
    if (we) chk("mem_wdata", 32'(owd), 32'(wd));
  endtask

  initial begin
    sc_rst = 1'b0; sc_inc = 1'b0; sat_done = 1'b0;
    @(posedge clk_1); #1;
    sc_rst = 1'b1; sc_inc = 1'b1;
    for (int k = 1; k <= 65600; k++) begin
      @(posedge clk_1); #1;
      if (k == 1)     sat_obs[0] = sc_count;
      if (k == 65534) sat_obs[1] = sc_count;
      if (k == 65535) sat_obs[2] = sc_count;
      if (k == 65600) sat_obs[3] = sc_count;
    end
    sc_inc = 1'b0;
    sat_done = 1'b1;
  end

  initial begin
    int cnt, acks;
    logic [ADDR_W-1:0] ra;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_hit_cnt = '0; exp_miss_cnt = '0; exp_rdata = '0;
    pre_we = 1'b1; pre_addr = 16'h0085; pre_data = 8'h3C;
    @(posedge clk_1); #1;
    pre_we = 1'b0;
    rval[idx_of(16'h0085)] = 1'b1;
    rtag[idx_of(16'h0085)] = tag_of(16'h0085);
    ref_mem[16'h0085] = 8'h3C;
    mem[16'h0085] = 8'h3C;

    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_c_w_rd", 32'(c_w_rd), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_c_addr", 32'(c_addr), 32'd0);
    chk("rst_c_wdata", 32'(c_wdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);

    rst = 1'b1;
    run_txn(1'b0, 16'h0085, 8'h00, 1, 1'b0);
    mem[16'h1205] = 8'hA7; ref_mem[16'h1205] = 8'hA7;
    run_txn(1'b0, 16'h1205, 8'h00, 3, 1'b0);
    run_txn(1'b1, 16'h0200, 8'h55, 1, 1'b0);
    run_txn(1'b0, 16'h0200, 8'h00, 2, 1'b0);

    // Abandon a read miss by resetting in its second memory-request cycle.
    cpu_we = 1'b0; cpu_addr = 16'h3305; cpu_req = 1'b1;
    @(posedge clk_1); #1;
    cpu_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < BUDGET && cnt < 2; k++) begin
      @(posedge clk_1); #1;
      if (mem_req) cnt++;
    end
    chk("rst_mid_mreq_seen", 32'(cnt), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_mid_miss_cnt", 32'(miss_cnt), 32'd0);
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_1); #1;
      if (cpu_ack) acks++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_1); #1;
      if (cpu_ack) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'd0);
    exp_hit_cnt = '0; exp_miss_cnt = '0; exp_rdata = '0;
    run_txn(1'b0, 16'h3305, 8'h00, 2, 1'b0);

    for (int t = 0; t < 200; t++) begin
      ra = 16'(($urandom_range(0, 3) << C_TAG_LSB) | $urandom_range(0, 7));
      run_txn($urandom_range(0, 9) < 3, ra, 8'($urandom), $urandom_range(1, 4),
              1'($urandom_range(0, 1)));
    end
    for (int t = 0; t < 20; t++) begin
      ra = 16'(($urandom_range(0, 3) << C_TAG_LSB) | $urandom_range(0, 7));
      run_txn($urandom_range(0, 9) < 3, ra, 8'($urandom), $urandom_range(1, 3), 1'b1);
    end
    cpu_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_1); #1;
      if (cpu_ack || mem_req) acks++;
    end
    chk("idle_quiet", 32'(acks), 32'd0);

    for (int k = 0; k < 70000 && !sat_done; k++) @(posedge clk_1);
    #1;
    chk("sat_done", 32'(sat_done), 32'd1);
    chk("sat_first", 32'(sat_obs[0]), 32'h0001);
    chk("sat_near", 32'(sat_obs[1]), 32'hFFFE);
    chk("sat_top", 32'(sat_obs[2]), 32'hFFFF);
    chk("sat_stay", 32'(sat_obs[3]), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
